// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data memory arbiter
package dmem_pkg;

    // Arbitration states: CPU priority, one forced debug grant, debug exclusive lock.
    typedef enum logic [1:0] {
        CPU_PRI   = 2'd0,
        DBG_FORCE = 2'd1,
        DBG_LOCK  = 2'd2
    } arb_state_t;

    // Which port owns the read data returning from the RAM this cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/dmem_rd_return.sv
// rtl/dmem_rd_return.sv - steers synchronous RAM read data back to the port that issued the read
//
// Ports:
//   Clk, Reset              clock, synchronous active-high reset
//   cpu_rd_gnt, dbg_rd_gnt  a read was granted to that port this cycle
//   mem_rdata               RAM read data (one cycle after the address)
//   cpu_rvalid, cpu_rdata   CPU read return
//   dbg_rvalid, dbg_rdata   debug read return
module dmem_rd_return
    import dmem_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_rd_gnt,
    input  logic              dbg_rd_gnt,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata
);

    owner_t            owner_q;
    logic [DATA_W-1:0] cpu_hold;
    logic [DATA_W-1:0] dbg_hold;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            owner_q <= OWN_NONE;
        end else if (cpu_rd_gnt) begin
            owner_q <= OWN_CPU;
        end else if (dbg_rd_gnt) begin
            owner_q <= OWN_DBG;
        end else begin
            owner_q <= OWN_NONE;
        end
    end

    // Gating with Reset drops a read whose data would land in a reset cycle.
    assign cpu_rvalid = ~Reset & (owner_q == OWN_CPU);
    assign dbg_rvalid = ~Reset & (owner_q == OWN_DBG);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cpu_hold <= '0;
            dbg_hold <= '0;
        end else begin
            if (cpu_rvalid) cpu_hold <= mem_rdata;
            if (dbg_rvalid) dbg_hold <= mem_rdata;
        end
    end

    // Live RAM data on the valid cycle, last returned word otherwise.
    assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_hold;
    assign dbg_rdata = dbg_rvalid ? mem_rdata : dbg_hold;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data memory arbiter, CPU priority with bounded debug starvation and debug lock
//
// Ports:
//   Clk, Reset                                 clock, synchronous active-high reset
//   cpu_req/cpu_wr/cpu_addr/cpu_wdata/cpu_gnt  CPU request and grant
//   cpu_rvalid/cpu_rdata                       CPU read return
//   dbg_req/dbg_wr/dbg_addr/dbg_wdata/dbg_gnt  debug request and grant
//   dbg_lock                                   keep exclusive ownership after the next debug grant
//   dbg_rvalid/dbg_rdata                       debug read return
//   mem_addr/mem_wr/mem_wdata/mem_rdata        RAM macro interface
//   locked                                     arbiter is in the debug lock state
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_wr,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              locked
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    arb_state_t          state, state_d;
    logic [STARVE_W-1:0] starve_cnt, starve_d;
    logic [ADDR_W-1:0]   last_addr;
    logic [DATA_W-1:0]   last_wdata;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= CPU_PRI;
            starve_cnt <= '0;
        end else begin
            state      <= state_d;
            starve_cnt <= starve_d;
        end
    end

    // Next-state and starvation counter
    always_comb begin
        state_d  = state;
        starve_d = starve_cnt;
        case (state)
            CPU_PRI: begin
                if (dbg_gnt) begin
                    starve_d = '0;
                    if (dbg_lock) state_d = DBG_LOCK;
                end else if (cpu_req && dbg_req) begin
                    starve_d = (starve_cnt == '1) ? starve_cnt : starve_cnt + 4'd1;
                    if (starve_d >= STARVE_LIM) state_d = DBG_FORCE;
                end
            end
            DBG_FORCE: begin
                starve_d = '0;
                state_d  = dbg_lock ? DBG_LOCK : CPU_PRI;
            end
            DBG_LOCK: begin
                starve_d = '0;
                if (!dbg_lock) state_d = CPU_PRI;
            end
            default: begin
                starve_d = '0;
                state_d  = CPU_PRI;
            end
        endcase
    end

    // Grant outputs
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!Reset) begin
            case (state)
                CPU_PRI: begin
                    cpu_gnt = cpu_req;
                    dbg_gnt = dbg_req & ~cpu_req;
                end
                DBG_FORCE: dbg_gnt = dbg_req;
                DBG_LOCK:  dbg_gnt = dbg_req;
                default:   ;
            endcase
        end
    end

    assign locked = (state == DBG_LOCK);

    // The RAM sees the granted port directly; with no grant it keeps the last
    // presented address/data so the macro pins stay quiet.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_addr  <= '0;
            last_wdata <= '0;
        end else if (cpu_gnt || dbg_gnt) begin
            last_addr  <= mem_addr;
            last_wdata <= mem_wdata;
        end
    end

    assign mem_addr  = cpu_gnt ? cpu_addr  : (dbg_gnt ? dbg_addr  : last_addr);
    assign mem_wdata = cpu_gnt ? cpu_wdata : (dbg_gnt ? dbg_wdata : last_wdata);
    assign mem_wr    = (cpu_gnt & cpu_wr) | (dbg_gnt & dbg_wr);

    dmem_rd_return #(
        .DATA_W(DATA_W)
    ) u_rd_return (
        .Clk        (Clk),
        .Reset      (Reset),
        .cpu_rd_gnt (cpu_gnt & ~cpu_wr),
        .dbg_rd_gnt (dbg_gnt & ~dbg_wr),
        .mem_rdata  (mem_rdata),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata)
    );

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port 256x16 data memory between the processor controller (D_Addr/D_Wr path) and a debug/loader port.
- Grants one access per cycle with CPU priority.
- Bounds debug starvation and supports a debug lock for exclusive bursts.
- Returns read data with a fixed 1-cycle latency, matching the synchronous RAM.
- Sits between the controller/datapath and the RAM macro.

Parameters:
ADDR_W, 8, data memory address width
DATA_W, 16, data word width
STARVE_MAX, 4, consecutive denied debug cycles before a forced debug grant (1..15)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request, held until granted
cpu_wr  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU access issued this cycle
cpu_rvalid  out  1  CPU read data valid (cycle after a read grant)
cpu_rdata  out  DATA_W  CPU read data
dbg_req  in  1  debug access request, held until granted
dbg_wr  in  1  1 = write, 0 = read
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_lock  in  1  request exclusive ownership after the next debug grant
dbg_gnt  out  1  debug access issued this cycle
dbg_rvalid  out  1  debug read data valid
dbg_rdata  out  DATA_W  debug read data
mem_addr  out  ADDR_W  RAM address
mem_wr  out  1  RAM write enable
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after address
locked  out  1  arbiter in DBG_LOCK state

Behaviour:
- Handshake: requester holds req/wr/addr/wdata stable until gnt=1.
- gnt is combinational from state and req. A granted access is presented to the RAM in the same cycle (mem_* muxed from the granted port).
- At most one of cpu_gnt/dbg_gnt is 1 in any cycle.
- No grant: mem_wr=0; mem_addr/mem_wdata hold their last values (registered mux select).
- Read return:
  - A read granted in cycle N gives <port>_rvalid=1 in cycle N+1, with <port>_rdata=mem_rdata.
  - The owner tag is registered in cycle N.
  - rdata holds its value until the next rvalid for that port.
  - Writes never produce rvalid.
- State machine (3 states):
  - CPU_PRI (reset state):
    - cpu_req grants CPU.
    - Otherwise dbg_req grants debug.
    - If dbg_req and cpu_req are both 1, debug is denied and starve_cnt increments.
    - When starve_cnt reaches STARVE_MAX, go to DBG_FORCE.
    - Any debug grant clears starve_cnt.
  - DBG_FORCE:
    - Debug granted unconditionally (dbg_req is still high by the handshake rule).
    - CPU denied.
    - starve_cnt cleared.
    - Next state is CPU_PRI; if dbg_lock=1 in the grant cycle, next state is DBG_LOCK.
  - CPU_PRI transition to DBG_LOCK: a debug grant with dbg_lock=1.
  - DBG_LOCK:
    - Only debug is granted (when dbg_req=1).
    - CPU is always denied; starve_cnt is frozen at 0.
    - Return to CPU_PRI in the cycle after dbg_lock=0 is sampled. The lock-release cycle itself may still grant debug.
- Write-then-read to the same address on consecutive grants returns the new data (RAM write-first not required; the read is issued a cycle later).
- starve_cnt is 4 bits and saturates; never wraps.
- Reset (sync):
  - state=CPU_PRI, starve_cnt=0, rvalid tags cleared.
  - cpu_rvalid=dbg_rvalid=0, cpu_rdata=dbg_rdata=0.
  - mem_addr=0, mem_wdata=0, mem_wr=0, locked=0.
  - cpu_gnt=dbg_gnt=0 while Reset=1.
- Reset mid-operation: an outstanding read is dropped (no rvalid after Reset), and a lock is released.

Decomposition:
- Shared package dmem_pkg:
  - typedef enum logic [1:0] arb_state_t {CPU_PRI, DBG_FORCE, DBG_LOCK}
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_CPU, OWN_DBG}
  - localparam STARVE_W=4
- One sub-module, dmem_rd_return: the registered owner tag plus the rvalid/rdata steering.
- Arbitration FSM, starvation counter and request mux stay in dmem_arbiter.

Test Plan:
- Reset=1 for 2 cycles with cpu_req=dbg_req=1 -> both gnt=0, mem_wr=0, rvalid=0, locked=0. After release, cpu_gnt=1 on the first cycle.
- CPU write addr 8'hBC data 16'h1234, then CPU read 8'hBC -> mem_wr=1 in the write grant cycle. cpu_rvalid=1 one cycle after the read grant, with cpu_rdata=16'h1234 and dbg_rvalid=0.
- cpu_req held high, dbg read 8'h10 held high, STARVE_MAX=4 -> dbg denied 4 cycles, dbg_gnt=1 in cycle 5 with cpu_gnt=0, then cpu_gnt resumes in cycle 6.
- dbg_lock=1 with a dbg write to 8'h00, then 3 debug writes 8'h01..8'h03 while cpu_req=1 -> locked=1 and cpu_gnt=0 throughout. Dropping dbg_lock gives cpu_gnt=1 one cycle later.
- Alternating grants: CPU read 8'h05, then debug read 8'h06 on the next cycle -> cpu_rvalid and dbg_rvalid fire on consecutive cycles, each with its own RAM data and no cross-delivery.
- Reset asserted in the cycle after a CPU read grant -> cpu_rvalid stays 0, state returns to CPU_PRI, locked=0.
